// File: rtl/wb_single_master_switch.sv
// ---------------------------------------------------------------------------
// wb_single_master_switch
//
// Registered Wishbone classic switch for a single initiator (the CPU) and two
// targets: target 0 (SRAM) and target 1 (peripheral window). Each access is
// decoded, forwarded with registered cyc/stb, and answered with a registered
// one-cycle ack or err. Unmapped addresses and targets that never answer end
// in a bus error so a runaway program cannot hang the bus.
//
// Handshake: the initiator presents a request by holding cyc&stb high until
// it sees ack or err; exactly one response pulse is returned per accepted
// request. A target completes the forwarded request by raising ack or err
// while its cyc&stb are high; cyc/stb drop at the edge that consumes that
// response. Dropping initiator cyc while forwarded abandons the access with
// no response.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   m_wb_*                   initiator side (cyc/stb/we/adr/sel/dat in,
//                            dat/ack/err out)
//   t0_wb_*, t1_wb_*         target side (cyc/stb/we/adr/sel/dat out,
//                            dat/ack/err in)
//   err_adr_o                address of the most recent errored access
//   timeout_o                one-cycle pulse when a timeout error is issued
//   dbg_state                current FSM state (0 IDLE, 1 FWD, 2 RESP)
// ---------------------------------------------------------------------------
module wb_single_master_switch #(
  parameter int unsigned          DEC_W   = 8,
  parameter logic [DEC_W-1:0]     T0_ADDR = 8'h00,
  parameter int unsigned          DECP_W  = 4,
  parameter logic [DECP_W-1:0]    T1_ADDR = 4'h9,
  parameter int unsigned          TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m_wb_cyc_i,
  input  logic        m_wb_stb_i,
  input  logic        m_wb_we_i,
  input  logic [31:0] m_wb_adr_i,
  input  logic [3:0]  m_wb_sel_i,
  input  logic [31:0] m_wb_dat_i,
  output logic [31:0] m_wb_dat_o,
  output logic        m_wb_ack_o,
  output logic        m_wb_err_o,
  output logic        t0_wb_cyc_o,
  output logic        t0_wb_stb_o,
  output logic        t0_wb_we_o,
  output logic [31:0] t0_wb_adr_o,
  output logic [3:0]  t0_wb_sel_o,
  output logic [31:0] t0_wb_dat_o,
  input  logic [31:0] t0_wb_dat_i,
  input  logic        t0_wb_ack_i,
  input  logic        t0_wb_err_i,
  output logic        t1_wb_cyc_o,
  output logic        t1_wb_stb_o,
  output logic        t1_wb_we_o,
  output logic [31:0] t1_wb_adr_o,
  output logic [3:0]  t1_wb_sel_o,
  output logic [31:0] t1_wb_dat_o,
  input  logic [31:0] t1_wb_dat_i,
  input  logic        t1_wb_ack_i,
  input  logic        t1_wb_err_i,
  output logic [31:0] err_adr_o,
  output logic        timeout_o,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT);
  localparam bit          TO_EN  = (TIMEOUT != 0);

  state_t      state;
  logic [15:0] cnt;
  logic        tgt;      // 0: target 0 selected, 1: target 1 selected
  logic [31:0] req_adr;
  logic        req_we;

  logic        t0_hit, t1_hit;
  logic        tgt_ack, tgt_err;
  logic [31:0] tgt_dat;
  logic        to_hit;
  logic        fwd_exit;

  assign dbg_state = state;

  assign t0_hit = (m_wb_adr_i[31 -: DEC_W]  == T0_ADDR);
  assign t1_hit = (m_wb_adr_i[31 -: DECP_W] == T1_ADDR);

  assign tgt_ack = tgt ? t1_wb_ack_i : t0_wb_ack_i;
  assign tgt_err = tgt ? t1_wb_err_i : t0_wb_err_i;
  assign tgt_dat = tgt ? t1_wb_dat_i : t0_wb_dat_i;

  // cnt holds the number of completed FWD cycles; the current FWD cycle is
  // number cnt+1, so the forced error fires at the end of cycle TIMEOUT.
  assign to_hit   = TO_EN && (({1'b0, cnt} + 17'd1) >= TO_LIM);
  assign fwd_exit = !m_wb_cyc_i || tgt_err || tgt_ack || to_hit;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      tgt         <= 1'b0;
      req_adr     <= '0;
      req_we      <= 1'b0;
      m_wb_dat_o  <= '0;
      m_wb_ack_o  <= 1'b0;
      m_wb_err_o  <= 1'b0;
      err_adr_o   <= '0;
      timeout_o   <= 1'b0;
      t0_wb_cyc_o <= 1'b0;
      t0_wb_stb_o <= 1'b0;
      t0_wb_we_o  <= 1'b0;
      t0_wb_adr_o <= '0;
      t0_wb_sel_o <= '0;
      t0_wb_dat_o <= '0;
      t1_wb_cyc_o <= 1'b0;
      t1_wb_stb_o <= 1'b0;
      t1_wb_we_o  <= 1'b0;
      t1_wb_adr_o <= '0;
      t1_wb_sel_o <= '0;
      t1_wb_dat_o <= '0;
    end else begin
      // Response pulses last a single cycle.
      m_wb_ack_o <= 1'b0;
      m_wb_err_o <= 1'b0;
      timeout_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (m_wb_cyc_i && m_wb_stb_i) begin
            req_adr <= m_wb_adr_i;
            req_we  <= m_wb_we_i;
            cnt     <= '0;
            // Target 0 is decoded first so it wins on overlapping windows.
            if (t0_hit) begin
              tgt         <= 1'b0;
              t0_wb_cyc_o <= 1'b1;
              t0_wb_stb_o <= 1'b1;
              t0_wb_we_o  <= m_wb_we_i;
              t0_wb_adr_o <= m_wb_adr_i;
              t0_wb_sel_o <= m_wb_sel_i;
              t0_wb_dat_o <= m_wb_dat_i;
              state       <= FWD;
            end else if (t1_hit) begin
              tgt         <= 1'b1;
              t1_wb_cyc_o <= 1'b1;
              t1_wb_stb_o <= 1'b1;
              t1_wb_we_o  <= m_wb_we_i;
              t1_wb_adr_o <= m_wb_adr_i;
              t1_wb_sel_o <= m_wb_sel_i;
              t1_wb_dat_o <= m_wb_dat_i;
              state       <= FWD;
            end else begin
              m_wb_err_o <= 1'b1;
              err_adr_o  <= m_wb_adr_i;
              state      <= RESP;
            end
          end
        end

        FWD: begin
          if (fwd_exit) begin
            t0_wb_cyc_o <= 1'b0;
            t0_wb_stb_o <= 1'b0;
            t0_wb_we_o  <= 1'b0;
            t0_wb_adr_o <= '0;
            t0_wb_sel_o <= '0;
            t0_wb_dat_o <= '0;
            t1_wb_cyc_o <= 1'b0;
            t1_wb_stb_o <= 1'b0;
            t1_wb_we_o  <= 1'b0;
            t1_wb_adr_o <= '0;
            t1_wb_sel_o <= '0;
            t1_wb_dat_o <= '0;
          end
          // Abort beats everything; a target err beats a same-cycle ack; a
          // real target response beats a coincident timeout.
          if (!m_wb_cyc_i) begin
            state <= IDLE;
          end else if (tgt_err) begin
            m_wb_err_o <= 1'b1;
            err_adr_o  <= req_adr;
            state      <= RESP;
          end else if (tgt_ack) begin
            m_wb_ack_o <= 1'b1;
            // Read data is only meaningful on reads; writes keep the old value.
            if (!req_we) m_wb_dat_o <= tgt_dat;
            state <= RESP;
          end else if (to_hit) begin
            m_wb_err_o <= 1'b1;
            timeout_o  <= 1'b1;
            err_adr_o  <= req_adr;
            state      <= RESP;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end

        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
